// File: rtl/hynoc_ingress_routing_mcast_fsm.sv
// HyNoC ingress multicast route decoder: decode the current hop into an egress request mask,
// collect every requested grant, emit the decremented header, then hold the path until packet end.
// Optional grant-wait timeout is enabled by defining HYNOC_MCAST_TIMEOUT_EN.
module hynoc_ingress_routing_mcast_fsm #(
  parameter int unsigned NB_PORTS         = 5,
  parameter int unsigned INDEX_WIDTH      = 4,
  parameter int unsigned PAYLOAD_WIDTH    = 32,
  parameter int unsigned FLIT_WIDTH       = PAYLOAD_WIDTH + 1,
  parameter int unsigned FLIT_PROTO_WIDTH = 4,
  parameter int unsigned TIMEOUT_CYCLES   = 256
) (
  input  logic                    router_clk,
  input  logic                    router_rst_n,
  input  logic                    hdr_valid,
  input  logic [FLIT_WIDTH-1:0]   hdr_data,
  output logic                    hdr_ready,
  input  logic                    packet_end,
  input  logic [NB_PORTS-2:0]     from_egress_grant,
  output logic [NB_PORTS-2:0]     to_egress_request,
  output logic                    route_done,
  output logic                    new_header_write,
  output logic [FLIT_WIDTH-1:0]   new_header,
  output logic                    route_error,
  output logic                    route_timeout
);

  localparam int unsigned HOP_WIDTH = NB_PORTS - 1;
  localparam int unsigned NB_HOPS   = (PAYLOAD_WIDTH - INDEX_WIDTH - FLIT_PROTO_WIDTH) / HOP_WIDTH;

  if (TIMEOUT_CYCLES < 2 || FLIT_WIDTH < PAYLOAD_WIDTH + 1 || NB_HOPS == 0) begin : g_bad_cfg
    $error("hynoc_ingress_routing_mcast_fsm: invalid parameter set");
  end

  typedef enum logic [1:0] {IDLE, REQ, ACTIVE} state_e;

  state_e                 state_q, state_d;
  logic [HOP_WIDTH-1:0]   req_q, req_d;
  logic [HOP_WIDTH-1:0]   seen_q, seen_d;
  logic [FLIT_WIDTH-1:0]  nh_pend_q, nh_pend_d;
  logic [FLIT_WIDTH-1:0]  new_header_q, new_header_d;
  logic                   last_hop_q, last_hop_d;
  logic                   done_q, done_d;
  logic                   nhw_q, nhw_d;
  logic                   err_q, err_d;
  logic [HOP_WIDTH-1:0]   hop_mask;
  logic [31:0]            hdr_idx;
  logic                   complete;

`ifdef HYNOC_MCAST_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             expired;

  assign expired       = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign route_timeout = tmo_q;
`else
  assign route_timeout = 1'b0;
`endif

  // Hop slots past NB_HOPS do not exist in the header and decode as a null hop.
  always_comb begin
    hdr_idx  = 32'(hdr_data[INDEX_WIDTH-1:0]);
    hop_mask = '0;
    for (int unsigned i = 0; i < NB_HOPS; i++) begin
      if (hdr_idx == i) hop_mask = hdr_data[(i+1)*HOP_WIDTH+INDEX_WIDTH-1 -: HOP_WIDTH];
    end
  end

  assign complete = ((seen_q | (from_egress_grant & req_q)) == req_q);

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    seen_d       = seen_q;
    nh_pend_d    = nh_pend_q;
    new_header_d = new_header_q;
    last_hop_d   = last_hop_q;
    done_d       = 1'b0;
    nhw_d        = 1'b0;
    err_d        = 1'b0;
`ifdef HYNOC_MCAST_TIMEOUT_EN
    cnt_d        = '0;
    tmo_d        = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (hdr_valid) begin
          nh_pend_d  = {hdr_data[FLIT_WIDTH-1:INDEX_WIDTH], hdr_data[INDEX_WIDTH-1:0] - INDEX_WIDTH'(1)};
          last_hop_d = (hdr_data[INDEX_WIDTH-1:0] == '0);
          if (hop_mask == '0) begin
            err_d = 1'b1;
          end else begin
            req_d   = hop_mask;
            seen_d  = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        seen_d = seen_q | (from_egress_grant & req_q);
`ifdef HYNOC_MCAST_TIMEOUT_EN
        cnt_d  = cnt_q + CNT_W'(1);
`endif
        if (complete) begin
          state_d = ACTIVE;
          done_d  = 1'b1;
          nhw_d   = !last_hop_q;
          if (!last_hop_q) new_header_d = nh_pend_q;
        end
`ifdef HYNOC_MCAST_TIMEOUT_EN
        else if (expired) begin
          state_d = IDLE;
          req_d   = '0;
          tmo_d   = 1'b1;
        end
`endif
      end
      ACTIVE: begin
        if (packet_end) begin
          req_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = '0;
      end
    endcase
  end

  always_ff @(posedge router_clk or negedge router_rst_n) begin
    if (!router_rst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      seen_q       <= '0;
      nh_pend_q    <= '0;
      new_header_q <= '0;
      last_hop_q   <= 1'b0;
      done_q       <= 1'b0;
      nhw_q        <= 1'b0;
      err_q        <= 1'b0;
`ifdef HYNOC_MCAST_TIMEOUT_EN
      cnt_q        <= '0;
      tmo_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      seen_q       <= seen_d;
      nh_pend_q    <= nh_pend_d;
      new_header_q <= new_header_d;
      last_hop_q   <= last_hop_d;
      done_q       <= done_d;
      nhw_q        <= nhw_d;
      err_q        <= err_d;
`ifdef HYNOC_MCAST_TIMEOUT_EN
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign hdr_ready         = (state_q == IDLE);
  assign to_egress_request = req_q;
  assign route_done        = done_q;
  assign new_header_write  = nhw_q;
  assign new_header        = new_header_q;
  assign route_error       = err_q;

endmodule

// File: doc/hynoc_ingress_routing_mcast_fsm.md
# hynoc_ingress_routing_mcast_fsm

Sequential multicast route decoder for a HyNoC router ingress port. It accepts a routing header flit through a valid/ready handshake and decodes the current hop into a multicast egress request mask. It collects grants from every requested egress port, then emits the countdown-updated header and holds the path until end of packet. It sits between the ingress FIFO read side and the egress arbiters.

## Interface
- NB_PORTS, 5, router port count; hop width HOP_WIDTH = NB_PORTS-1
- INDEX_WIDTH, 4, header hop-index width
- PAYLOAD_WIDTH, 32, flit payload width
- FLIT_WIDTH, PAYLOAD_WIDTH+1, flit width; must be ≥ PAYLOAD_WIDTH+1
- FLIT_PROTO_WIDTH, 4, protocol bits reserved at payload top; NB_HOPS = (PAYLOAD_WIDTH-INDEX_WIDTH-FLIT_PROTO_WIDTH)/HOP_WIDTH
- TIMEOUT_CYCLES, 256, grant-wait limit (used only with timeout macro), ≥2
- router_clk  in  1  router clock
- router_rst_n  in  1  asynchronous active-low reset
- hdr_valid  in  1  header flit present
- hdr_data  in  FLIT_WIDTH  header flit; hops at [(i+1)*HOP_WIDTH+INDEX_WIDTH-1 -: HOP_WIDTH], index at [INDEX_WIDTH-1:0]
- hdr_ready  out  1  header accepted this cycle when high with hdr_valid
- packet_end  in  1  tail flit of current packet forwarded
- from_egress_grant  in  NB_PORTS-1  per-egress grant, level
- to_egress_request  out  NB_PORTS-1  registered multicast request mask
- route_done  out  1  one-cycle pulse: all requested grants collected
- new_header_write  out  1  one-cycle pulse with route_done when captured index ≠ 0
- new_header  out  FLIT_WIDTH  {hdr_data[FLIT_WIDTH-1:INDEX_WIDTH], index-1}, valid while new_header_write
- route_error  out  1  one-cycle pulse: null hop
- route_timeout  out  1  one-cycle pulse: grant wait expired

## Operation
- States: IDLE, REQ, ACTIVE.
- IDLE: hdr_ready=1. On hdr_valid, latch hdr_data. Compute mask = hops[index]; hops with index ≥ NB_HOPS read as 0.
  - mask==0: pulse route_error, stay IDLE, header dropped.
  - Otherwise: load to_egress_request=mask, clear grant_seen, go REQ.
- REQ: grant_seen |= from_egress_grant & mask each cycle. Completion when (grant_seen | (from_egress_grant & mask)) == mask: next edge go ACTIVE, pulse route_done, pulse new_header_write if index≠0, drive new_header.
- Grants on unrequested ports are ignored. Grant deassertion after capture does not un-collect it.
- packet_end is ignored in IDLE and REQ.
- ACTIVE: hold to_egress_request. On packet_end, clear requests and go IDLE at next edge.
- Index arithmetic is INDEX_WIDTH-bit modulo; index 0 gives no header write (last hop).
- new_header holds last value between pulses.

## Timing
- Reset (async assert, sync deassert via clock edge): state IDLE, all outputs 0 except hdr_ready=1, grant_seen=0, timeout counter 0.
- Header accepted at edge N gives request visible after N. If all grants are present in cycle N+1, route_done/new_header_write are high in cycle N+2.
- hdr_ready is a decode of state only; it does not depend on hdr_valid.
- Back-to-back: packet_end at edge M puts state in IDLE after M, so the next header is accepted at edge M+1 at earliest.
- Reset mid-REQ/ACTIVE: requests drop immediately (asynchronous) and the captured header is discarded.

## Configuration
- HYNOC_MCAST_TIMEOUT_EN defined: a counter runs in REQ, cleared on REQ entry. If completion has not occurred by the TIMEOUT_CYCLES-th REQ cycle:
  - clear requests, pulse route_timeout, return to IDLE, drop header.
  - Completion in that same cycle wins over timeout.
- Not defined: REQ waits indefinitely; route_timeout tied 0; no counter logic.

## Test plan
(NB_PORTS=5, INDEX_WIDTH=4, PAYLOAD_WIDTH=32, FLIT_PROTO_WIDTH=4 → NB_HOPS=6)
- Unicast, all grants immediate: hdr index=2, hop2=4'b0100, grant=4'b0100 → request 4'b0100 in the cycle after accept; route_done and new_header_write one cycle later; new_header index=1, upper bits unchanged.
- Staggered multicast: hop0=4'b1011, index=0; grants 4'b0001, then 4'b1000 (first dropped), then 4'b0010 → route_done on cycle after third grant; new_header_write=0; request held until packet_end.
- Null hop: index=7 (≥NB_HOPS) or hop=0 → route_error pulse, no request, hdr_ready stays 1.
- Back-to-back: packet_end in ACTIVE with hdr_valid high → request 0 next cycle, next header accepted one cycle later, not earlier.
- Async reset asserted mid-REQ → to_egress_request=0 without clock edge; after release, state IDLE, hdr_ready=1.
- Timeout (macro on, TIMEOUT_CYCLES=8): mask 4'b0011, only 4'b0001 granted → route_timeout pulse after 8 REQ cycles, requests cleared, no route_done; macro off → waits beyond 1000 cycles.
